// File: rtl/fcvt_issue_ctrl_if.sv
// Issue and CDB handshake bundle for the shared FP32-to-INT32 converter controller.
// The master side is the requesters plus the CDB consumer; the slave side is the controller.
interface fcvt_issue_ctrl_if #(
    parameter int TAG_W = 6
);
    logic             req0_valid;
    logic             req0_ready;
    logic [31:0]      req0_src;
    logic [TAG_W-1:0] req0_tag;
    logic             req1_valid;
    logic             req1_ready;
    logic [31:0]      req1_src;
    logic [TAG_W-1:0] req1_tag;
    logic             cdb_valid;
    logic             cdb_ready;
    logic [31:0]      cdb_data;
    logic [TAG_W-1:0] cdb_tag;

    modport master (
        output req0_valid, req0_src, req0_tag,
        output req1_valid, req1_src, req1_tag,
        input  req0_ready, req1_ready,
        input  cdb_valid, cdb_data, cdb_tag,
        output cdb_ready
    );

    modport slave (
        input  req0_valid, req0_src, req0_tag,
        input  req1_valid, req1_src, req1_tag,
        output req0_ready, req1_ready,
        output cdb_valid, cdb_data, cdb_tag,
        input  cdb_ready
    );
endinterface

// File: rtl/fcvt_issue_ctrl.sv
// Shares one combinational FP32-to-INT32 converter between two issue ports:
// round-robin grant, registered operand, fixed settle delay, then a CDB result slot.
module fcvt_issue_ctrl #(
    parameter int TAG_W    = 6,
    parameter int CONV_LAT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    fcvt_issue_ctrl_if.slave    bus,
    output logic [31:0]         conv_in,
    input  logic [31:0]         conv_out,
    input  logic                flush,
    output logic                busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    localparam logic [1:0] CNT_LAST = 2'(CONV_LAT - 1);

    state_e           state_q, state_d;
    logic             rr_q, rr_d;
    logic [31:0]      op_q, op_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [31:0]      res_q, res_d;
    logic [1:0]       cnt_q, cnt_d;

    logic             grant_s;
    logic             grant_vld_s;
    logic             idle_s;
    logic             accept_s;
    logic             cnt_last_s;

    // Round-robin grant: rr_q names the preferred port, the other wins only when it is alone.
    always_comb begin
        grant_s     = 1'b0;
        grant_vld_s = 1'b0;
        if (rr_q == 1'b0) begin
            if (bus.req0_valid) begin
                grant_s     = 1'b0;
                grant_vld_s = 1'b1;
            end else if (bus.req1_valid) begin
                grant_s     = 1'b1;
                grant_vld_s = 1'b1;
            end else begin
                grant_s     = 1'b0;
                grant_vld_s = 1'b0;
            end
        end else begin
            if (bus.req1_valid) begin
                grant_s     = 1'b1;
                grant_vld_s = 1'b1;
            end else if (bus.req0_valid) begin
                grant_s     = 1'b0;
                grant_vld_s = 1'b1;
            end else begin
                grant_s     = 1'b0;
                grant_vld_s = 1'b0;
            end
        end
    end

    assign idle_s     = (state_q == S_IDLE);
    assign accept_s   = idle_s && !flush && grant_vld_s;
    assign cnt_last_s = (cnt_q == CNT_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush overrides every transition.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept_s) begin
                        state_d = S_CONV;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_CONV: begin
                    if (cnt_last_s) begin
                        state_d = S_HOLD;
                    end else begin
                        state_d = S_CONV;
                    end
                end
                S_HOLD: begin
                    if (bus.cdb_ready) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_HOLD;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q  <= 1'b0;
            op_q  <= 32'd0;
            tag_q <= '0;
            res_q <= 32'd0;
            cnt_q <= 2'd0;
        end else begin
            rr_q  <= rr_d;
            op_q  <= op_d;
            tag_q <= tag_d;
            res_q <= res_d;
            cnt_q <= cnt_d;
        end
    end

    // Datapath next values: flush only clears the settle counter, operand and result are kept.
    always_comb begin
        rr_d  = rr_q;
        op_d  = op_q;
        tag_d = tag_q;
        res_d = res_q;
        cnt_d = cnt_q;
        if (flush) begin
            cnt_d = 2'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept_s) begin
                        op_d  = grant_s ? bus.req1_src : bus.req0_src;
                        tag_d = grant_s ? bus.req1_tag : bus.req0_tag;
                        cnt_d = 2'd0;
                        rr_d  = ~grant_s;
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                S_CONV: begin
                    if (cnt_last_s) begin
                        res_d = conv_out;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
                S_HOLD: begin
                    cnt_d = cnt_q;
                end
                default: begin
                    cnt_d = 2'd0;
                end
            endcase
        end
    end

    // Outputs; ready is gated by rst_n so nothing looks accepted while reset is held.
    always_comb begin
        bus.req0_ready = rst_n && accept_s && (grant_s == 1'b0);
        bus.req1_ready = rst_n && accept_s && (grant_s == 1'b1);
        bus.cdb_valid  = (state_q == S_HOLD);
        bus.cdb_data   = res_q;
        bus.cdb_tag    = tag_q;
        conv_in        = op_q;
        busy           = !idle_s;
    end

endmodule

// File: tb/tb_fcvt_issue_ctrl.sv
// Bench for fcvt_issue_ctrl: three instances (CONV_LAT 1, 3, 4) share directed stimulus and
// are checked every cycle against a pending/age transaction model plus hand-computed literals.
module tb_fcvt_issue_ctrl;
    localparam int TAG_W = 6;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req0_valid, req1_valid, cdb_ready, flush;
    logic [31:0]      req0_src, req1_src;
    logic [TAG_W-1:0] req0_tag, req1_tag;

    logic             d_rdy0 [3];
    logic             d_rdy1 [3];
    logic             d_valid [3];
    logic             d_busy [3];
    logic [31:0]      d_data [3];
    logic [31:0]      d_cin [3];
    logic [TAG_W-1:0] d_tag [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Reference FP32 -> INT32, truncating toward zero and saturating (NaN -> max positive).
    function automatic logic [31:0] fcvt(input logic [31:0] f);
        logic        s;
        int          e;
        logic [63:0] mag;
        s = f[31];
        e = int'(f[30:23]) - 127;
        if (f[30:23] == 8'hFF && f[22:0] != 23'd0) return 32'h7FFFFFFF;
        if (e < 0) return 32'd0;
        if (e >= 31) return s ? 32'h80000000 : 32'h7FFFFFFF;
        mag = ({40'd0, 1'b1, f[22:0]} << e) >> 23;
        return s ? (32'd0 - mag[31:0]) : mag[31:0];
    endfunction

    function automatic int lat_of(input int g);
        return (g == 0) ? 1 : ((g == 1) ? 3 : 4);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        fcvt_issue_ctrl_if #(.TAG_W(TAG_W)) bus ();
        logic [31:0] conv_in_w;
        logic [31:0] conv_out_w;
        logic        busy_w;

        assign bus.req0_valid = req0_valid;
        assign bus.req0_src   = req0_src;
        assign bus.req0_tag   = req0_tag;
        assign bus.req1_valid = req1_valid;
        assign bus.req1_src   = req1_src;
        assign bus.req1_tag   = req1_tag;
        assign bus.cdb_ready  = cdb_ready;
        assign conv_out_w     = fcvt(conv_in_w);

        fcvt_issue_ctrl #(.TAG_W(TAG_W), .CONV_LAT(lat_of(g))) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .bus      (bus.slave),
            .conv_in  (conv_in_w),
            .conv_out (conv_out_w),
            .flush    (flush),
            .busy     (busy_w)
        );

        assign d_rdy0[g]  = bus.req0_ready;
        assign d_rdy1[g]  = bus.req1_ready;
        assign d_valid[g] = bus.cdb_valid;
        assign d_data[g]  = bus.cdb_data;
        assign d_tag[g]   = bus.cdb_tag;
        assign d_cin[g]   = conv_in_w;
        assign d_busy[g]  = busy_w;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: per instance, an operation is pending from its accept edge; its result is
    // offered once `lat` edges have passed, and it retires on a clean handshake or a flush.
    bit               m_pend [3];
    int               m_age [3];
    bit               m_pref [3];
    logic [31:0]      m_op [3];
    logic [31:0]      m_res [3];
    logic [TAG_W-1:0] m_tag [3];

    int               xfer_cnt [3];
    logic [TAG_W-1:0] log_tag [64];
    logic [31:0]      log_data [64];
    int               log_n = 0;
    int               acc_cyc [64];
    int               acc_n = 0;
    int               cyc = 0;

    initial begin : compare
        bit e_r0, e_r1, e_v;
        int lat;
        for (int i = 0; i < 3; i++) begin
            xfer_cnt[i] = 0;
        end
        forever begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < 3; i++) begin
                lat = lat_of(i);
                if (!rst_n) begin
                    m_pend[i] = 1'b0;
                    m_age[i]  = 0;
                    m_pref[i] = 1'b0;
                    m_op[i]   = 32'd0;
                    m_res[i]  = 32'd0;
                    m_tag[i]  = '0;
                    chk($sformatf("u%0d_rst_ready0", i), 32'(d_rdy0[i]), 32'd0);
                    chk($sformatf("u%0d_rst_ready1", i), 32'(d_rdy1[i]), 32'd0);
                    chk($sformatf("u%0d_rst_valid", i), 32'(d_valid[i]), 32'd0);
                    chk($sformatf("u%0d_rst_busy", i), 32'(d_busy[i]), 32'd0);
                    chk($sformatf("u%0d_rst_data", i), d_data[i], 32'd0);
                    chk($sformatf("u%0d_rst_tag", i), 32'(d_tag[i]), 32'd0);
                    chk($sformatf("u%0d_rst_conv_in", i), d_cin[i], 32'd0);
                end else begin
                    e_r0 = !m_pend[i] && !flush && req0_valid && (!m_pref[i] || !req1_valid);
                    e_r1 = !m_pend[i] && !flush && req1_valid && (m_pref[i] || !req0_valid);
                    e_v  = m_pend[i] && (m_age[i] >= lat);
                    chk($sformatf("u%0d_ready0", i), 32'(d_rdy0[i]), 32'(e_r0));
                    chk($sformatf("u%0d_ready1", i), 32'(d_rdy1[i]), 32'(e_r1));
                    chk($sformatf("u%0d_cdb_valid", i), 32'(d_valid[i]), 32'(e_v));
                    chk($sformatf("u%0d_busy", i), 32'(d_busy[i]), 32'(m_pend[i]));
                    chk($sformatf("u%0d_conv_in", i), d_cin[i], m_op[i]);
                    if (e_v) begin
                        chk($sformatf("u%0d_cdb_data", i), d_data[i], m_res[i]);
                        chk($sformatf("u%0d_cdb_tag", i), 32'(d_tag[i]), 32'(m_tag[i]));
                    end
                    if (d_valid[i] && cdb_ready && !flush) begin
                        xfer_cnt[i]++;
                        if (i == 0 && log_n < 64) begin
                            log_tag[log_n]  = d_tag[0];
                            log_data[log_n] = d_data[0];
                            log_n++;
                        end
                    end
                    if (i == 0 && acc_n < 64 && ((d_rdy0[0] && req0_valid) || (d_rdy1[0] && req1_valid))) begin
                        acc_cyc[acc_n] = cyc;
                        acc_n++;
                    end
                    if (flush) begin
                        m_pend[i] = 1'b0;
                    end else if (m_pend[i]) begin
                        if (e_v) begin
                            if (cdb_ready) m_pend[i] = 1'b0;
                        end else begin
                            m_age[i]++;
                        end
                    end else if (e_r0) begin
                        m_pend[i] = 1'b1;
                        m_age[i]  = 0;
                        m_op[i]   = req0_src;
                        m_tag[i]  = req0_tag;
                        m_res[i]  = fcvt(req0_src);
                        m_pref[i] = 1'b1;
                    end else if (e_r1) begin
                        m_pend[i] = 1'b1;
                        m_age[i]  = 0;
                        m_op[i]   = req1_src;
                        m_tag[i]  = req1_tag;
                        m_res[i]  = fcvt(req1_src);
                        m_pref[i] = 1'b0;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n      = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        cdb_ready  = 1'b0;
        flush      = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    initial begin : timeout
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int base;
        req0_valid = 1'b0; req1_valid = 1'b0; cdb_ready = 1'b0; flush = 1'b0;
        req0_src = 32'd0; req1_src = 32'd0; req0_tag = '0; req1_tag = '0;

        // Reset then single issue, CONV_LAT=1.
        do_reset();
        chk("a_rst_valid", 32'(d_valid[0]), 32'd0);
        chk("a_rst_busy", 32'(d_busy[0]), 32'd0);
        req0_valid = 1'b1; req0_src = 32'h40700000; req0_tag = 6'd5; cdb_ready = 1'b1;
        #1;
        chk("a_ready0", 32'(d_rdy0[0]), 32'd1);
        step();
        req0_valid = 1'b0;
        #1;
        chk("a_valid_e0", 32'(d_valid[0]), 32'd0);
        step();
        chk("a_valid_e1", 32'(d_valid[0]), 32'd1);
        chk("a_data", d_data[0], 32'h00000003);
        chk("a_tag", 32'(d_tag[0]), 32'd5);
        step();
        chk("a_busy_after", 32'(d_busy[0]), 32'd0);
        chk("a_valid_after", 32'(d_valid[0]), 32'd0);
        repeat (6) step();

        // Round-robin contention.
        do_reset();
        base = log_n;
        req0_valid = 1'b1; req0_src = 32'hC0200000; req0_tag = 6'd1;
        req1_valid = 1'b1; req1_src = 32'h501502F9; req1_tag = 6'd2;
        cdb_ready = 1'b1;
        begin : rr_block
            int abase;
            abase = acc_n;
            repeat (13) step();
            req0_valid = 1'b0; req1_valid = 1'b0;
            chk("b_log_count", 32'(log_n - base), 32'd4);
            chk("b_tag0", 32'(log_tag[base]), 32'd1);
            chk("b_data0", log_data[base], 32'hFFFFFFFE);
            chk("b_tag1", 32'(log_tag[base+1]), 32'd2);
            chk("b_data1", log_data[base+1], 32'h7FFFFFFF);
            chk("b_tag2", 32'(log_tag[base+2]), 32'd1);
            chk("b_tag3", 32'(log_tag[base+3]), 32'd2);
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("b_accept_gap%0d", k), 32'(acc_cyc[abase+k+1] - acc_cyc[abase+k]), 32'd3);
            end
        end
        repeat (8) step();

        // Back-pressure.
        do_reset();
        req0_valid = 1'b1; req0_src = 32'h40700000; req0_tag = 6'd9; cdb_ready = 1'b0;
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_src = 32'h3F000000; req1_tag = 6'd10;
        step();
        for (int k = 0; k < 5; k++) begin
            chk("c_valid", 32'(d_valid[0]), 32'd1);
            chk("c_data", d_data[0], 32'h00000003);
            chk("c_tag", 32'(d_tag[0]), 32'd9);
            chk("c_ready0", 32'(d_rdy0[0]), 32'd0);
            chk("c_ready1", 32'(d_rdy1[0]), 32'd0);
            chk("c_busy", 32'(d_busy[0]), 32'd1);
            step();
        end
        cdb_ready = 1'b1;
        base = xfer_cnt[0];
        step();
        chk("c_xfer", 32'(xfer_cnt[0] - base), 32'd1);
        chk("c_xfer_tag", 32'(log_tag[log_n-1]), 32'd9);
        chk("c_ready1_after", 32'(d_rdy1[0]), 32'd1);
        step();
        req1_valid = 1'b0;
        repeat (8) step();

        // Flush in CONV (CONV_LAT=3 at cnt=1), then flush in HOLD.
        do_reset();
        req0_valid = 1'b1; req0_src = 32'h40700000; req0_tag = 6'd3; cdb_ready = 1'b1;
        step();
        req0_valid = 1'b0;
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("d_busy_flushed", 32'(d_busy[1]), 32'd0);
        for (int k = 0; k < 5; k++) begin
            chk("d_no_valid", 32'(d_valid[1]), 32'd0);
            step();
        end
        req0_valid = 1'b1; req0_src = 32'hC0200000; req0_tag = 6'd4;
        step();
        req0_valid = 1'b0;
        repeat (3) step();
        chk("d_hold_valid", 32'(d_valid[1]), 32'd1);
        flush = 1'b1;
        req0_valid = 1'b1; req0_src = 32'h40700000; req0_tag = 6'd6;
        #1;
        chk("d_flush_ready0", 32'(d_rdy0[1]), 32'd0);
        base = xfer_cnt[1];
        step();
        flush = 1'b0;
        #1;
        chk("d_no_xfer", 32'(xfer_cnt[1] - base), 32'd0);
        chk("d_busy_idle", 32'(d_busy[1]), 32'd0);
        chk("d_ready0_next", 32'(d_rdy0[1]), 32'd1);
        step();
        req0_valid = 1'b0;
        chk("d_busy_new", 32'(d_busy[1]), 32'd1);
        repeat (4) step();
        chk("d_new_xfer", 32'(xfer_cnt[1] - base), 32'd1);
        repeat (6) step();

        // CONV_LAT=4.
        do_reset();
        req0_valid = 1'b1; req0_src = 32'h3F000000; req0_tag = 6'd7; cdb_ready = 1'b1;
        step();
        req0_valid = 1'b0;
        chk("e_valid0", 32'(d_valid[2]), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk($sformatf("e_valid%0d", k), 32'(d_valid[2]), (k == 4) ? 32'd1 : 32'd0);
        end
        chk("e_data", d_data[2], 32'd0);
        chk("e_tag", 32'(d_tag[2]), 32'd7);
        repeat (5) step();

        // Async reset mid-HOLD.
        do_reset();
        req0_valid = 1'b1; req0_src = 32'h40700000; req0_tag = 6'd11; cdb_ready = 1'b0;
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_src = 32'hC0200000; req1_tag = 6'd12;
        repeat (5) step();
        chk("f_hold_pre", 32'(d_valid[2]), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("f_u%0d_valid", g), 32'(d_valid[g]), 32'd0);
            chk($sformatf("f_u%0d_busy", g), 32'(d_busy[g]), 32'd0);
            chk($sformatf("f_u%0d_ready0", g), 32'(d_rdy0[g]), 32'd0);
            chk($sformatf("f_u%0d_ready1", g), 32'(d_rdy1[g]), 32'd0);
        end
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        cdb_ready = 1'b1;
        #1;
        chk("f_ready1_first", 32'(d_rdy1[0]), 32'd1);
        chk("f_ready0_first", 32'(d_rdy0[0]), 32'd0);
        step();
        req1_valid = 1'b0;
        step();
        chk("f_valid", 32'(d_valid[0]), 32'd1);
        chk("f_tag", 32'(d_tag[0]), 32'd12);
        chk("f_data", d_data[0], 32'hFFFFFFFE);
        repeat (8) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
